// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexes NUM_DIGITS packed BCD digits onto a
// shared seven-segment bus with one-hot digit enables. A snapshot of all
// digits is taken once per scan frame so the display never tears.
module bcd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pre, pre_next;
  logic [IW-1:0]           idx, idx_next;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_next;
  logic                    lz_q, lz_next;
  logic                    wrap;
  logic [NUM_DIGITS:0]     zero_above;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;

  // Seven-segment decode {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Next-state of prescaler, scan index and snapshot.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and a latch cannot be inferred.
    pre_next    = pre;
    idx_next    = idx;
    shadow_next = shadow;
    lz_next     = lz_q;
    wrap        = 1'b0;
    if (en) begin
      if (pre == PRE_LAST) begin
        pre_next = '0;
        if (idx == IDX_LAST) begin
          idx_next    = '0;
          wrap        = 1'b1;
          shadow_next = bcd_in;
          lz_next     = blank_lz;
        end else begin
          idx_next = idx + 1'b1;
        end
      end else begin
        pre_next = pre + 1'b1;
      end
    end
  end

  // Output decode from next-state values so outputs track idx with no lag.
  always_comb begin
    zero_above[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (shadow_next[4*i +: 4] == 4'd0);
    end
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_next   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        an_next[i] = 1'b1;
        cur_digit  = shadow_next[4*i +: 4];
        cur_blank  = lz_next && (i != 0) && zero_above[i];
      end
    end
    seg_next = cur_blank ? 7'h00 : decode(cur_digit);
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Terminal values make the first enabled edge a frame start.
      pre         <= PRE_LAST;
      idx         <= IDX_LAST;
      shadow      <= '0;
      lz_q        <= 1'b0;
      an          <= '0;
      seg         <= '0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values, independent of statement order.
      pre         <= pre_next;
      idx         <= idx_next;
      shadow      <= shadow_next;
      lz_q        <= lz_next;
      frame_start <= wrap;
      if (en) begin
        an  <= an_next;
        seg <= seg_next;
      end else begin
        an  <= '0;
        seg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus random
// stimulus against a frame-arithmetic reference model.
module tb_bcd_scan_display;

  localparam int N = 4;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           blank_lz = 1'b0;
  logic [4*N-1:0] bcd_in = '0;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           frame_start;

  bcd_scan_display #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz),
    .bcd_in(bcd_in), .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: k = enabled edges since reset; everything else follows.
  int             k = 0;
  logic [4*N-1:0] snap = '0;
  logic           lz = 1'b0;
  logic [N-1:0]   exp_an = '0;
  logic [6:0]     exp_seg = '0;
  logic           exp_fs = 1'b0;

  function automatic logic [6:0] ref_dec(input int d);
    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d < 10) ? tbl[d] : 7'h40;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; exp_an = '0; exp_seg = '0; exp_fs = 1'b0;
  endtask

  // One clock edge: advance model, then sample DUT 1 time unit later.
  task automatic tick();
    int d;
    @(posedge clk);
    if (en) begin
      exp_fs = (k % (N*P) == 0);
      if (exp_fs) begin
        snap = bcd_in;
        lz   = blank_lz;
      end
      d = (k / P) % N;
      k++;
      exp_an = N'(1) << d;
      if (lz && d > 0 && (snap >> (4*d)) == 0) exp_seg = 7'h00;
      else exp_seg = ref_dec(int'(snap[4*d +: 4]));
    end else begin
      exp_an = '0; exp_seg = '0; exp_fs = 1'b0;
    end
    #1;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  initial begin
    int cnt;
    bit seen;

    // Reset state
    en = 1'b1; bcd_in = 16'h1234;
    #3;
    check("rst_an", 32'(an), 0);
    check("rst_seg", 32'(seg), 0);
    check("rst_fs", 32'(frame_start), 0);
    #9 rst_n = 1'b1;

    // Basic scan, mid-frame input change, leading-zero blanking
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 1)  begin check("s1_fs", 32'(frame_start), 1); check("s1_an", 32'(an), 1); check("s1_seg", 32'(seg), 32'h66); end
      if (i == 5)  begin check("s5_an", 32'(an), 2); check("s5_seg", 32'(seg), 32'h4F); end
      if (i == 9)  begin check("s9_an", 32'(an), 4); check("s9_seg", 32'(seg), 32'h5B); end
      if (i == 13) begin check("s13_an", 32'(an), 8); check("s13_seg", 32'(seg), 32'h06); end
      if (i == 17) check("s17_fs", 32'(frame_start), 1);
      if (i == 22) bcd_in = 16'h5678;
      if (i == 29) check("tear_seg", 32'(seg), 32'h06);
      if (i == 33) check("new_seg", 32'(seg), 32'h7F);
      if (i == 40) begin bcd_in = 16'h0070; blank_lz = 1'b1; end
      if (i == 49) check("lz_d0", 32'(seg), 32'h3F);
      if (i == 53) check("lz_d1", 32'(seg), 32'h07);
      if (i == 57) begin check("lz_d2_an", 32'(an), 4); check("lz_d2_seg", 32'(seg), 0); end
      if (i == 61) begin check("lz_d3_an", 32'(an), 8); check("lz_d3_seg", 32'(seg), 0); end
      if (i == 62) bcd_in = 16'h0000;
    end
    // All-zero frame, then dash frame
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 1)  check("z_d0", 32'(seg), 32'h3F);
      if (i == 5)  check("z_d1", 32'(seg), 0);
      if (i == 10) bcd_in = 16'h00A0;
      if (i == 21) check("dash_d1", 32'(seg), 32'h40);
      if (i == 25) check("dash_d2", 32'(seg), 0);
    end

    // en gap mid digit 2: 10 enabled edges, gap, then 6 more before wrap
    blank_lz = 1'b0; bcd_in = 16'h9876;
    for (int i = 0; i < 10; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    en = 1'b1;
    cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin
      tick();
      cnt++;
      seen = frame_start;
    end
    check("gap_resume_edges", 32'(cnt), 7);

    // Async reset between edges
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 0);
    check("arst_seg", 32'(seg), 0);
    check("arst_fs", 32'(frame_start), 0);
    model_reset();
    #2 rst_n = 1'b1;
    tick();
    check("arst_first_fs", 32'(frame_start), 1);
    check("arst_first_an", 32'(an), 1);

    // Random phase
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) begin
        bcd_in = 16'($urandom);
        if ($urandom_range(0, 1) == 1) bcd_in = bcd_in >> (4 * $urandom_range(1, 4));
      end
      if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
